dataout_fifo: RTL and testbench

Show-ahead synchronous FIFO that produces the `ready`/`read`/`data_out` output port. Upstream logic pushes bytes through a valid/ready write port. The block buffers them and presents the oldest byte on `data_out` with `ready` high. The downstream consumer pops the byte by asserting `read`. It is the stage directly upstream of the data-out consumer and is verified by the data-out agent on the read side.

---
 rtl/dataout_pkg.sv | 18 +
 rtl/dataout_fifo_mem.sv | 38 +++
 rtl/dataout_fifo.sv | 99 +++++++++
 tb/tb_dataout_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dataout_pkg.sv
// dataout_pkg
// Shared constants, types and helpers for the data-out FIFO slice.
//   DATAOUT_DW     : byte width of the data-out port (fixed at 8)
//   DATAOUT_DEPTH  : default FIFO depth (power of two)
//   dataout_byte_t : one byte of the data-out stream
//   ptr_w(depth)   : pointer width needed to address 'depth' entries
package dataout_pkg;

    localparam int DATAOUT_DW    = 8;
    localparam int DATAOUT_DEPTH = 16;

    typedef logic [7:0] dataout_byte_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dataout_fifo_mem.sv
// dataout_fifo_mem
// DEPTH x DW register array with one synchronous write port and one
// asynchronous read port. There is no reset; contents are only meaningful
// where the owning FIFO has written them.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module dataout_fifo_mem
    import dataout_pkg::*;
#(
    parameter int DW    = DATAOUT_DW,
    parameter int DEPTH = DATAOUT_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read: the addressed entry is always visible
    assign rdata = mem[raddr];

endmodule

// File: rtl/dataout_fifo.sv
// dataout_fifo
// Show-ahead synchronous FIFO feeding the data-out consumer. Upstream pushes
// bytes on a valid/ready port; the oldest byte is presented on data_out with
// ready high and is removed when the consumer asserts read.
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : write request
//   in_data   : write data
//   in_ready  : FIFO not full; write accepted when in_valid && in_ready
//   ready     : FIFO not empty; data_out is valid
//   read      : pop request from the consumer
//   data_out  : head-of-FIFO byte, 0 when ready is low
//   count     : current occupancy (0..DEPTH)
//   overflow  : sticky, a write was attempted while full
//   underflow : sticky, read was asserted while empty
module dataout_fifo
    import dataout_pkg::*;
#(
    parameter int DW    = DATAOUT_DW,
    parameter int DEPTH = DATAOUT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    output logic                       ready,
    input  logic                       read,
    output logic [DW-1:0]              data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [DW-1:0] mem_rdata;
    logic          push;
    logic          pop;

    // Status comes only from registered occupancy, so neither ready nor
    // in_ready depends combinationally on read or in_valid.
    assign ready    = (count != '0);
    assign in_ready = (count != CW'(DEPTH));

    // When full, in_ready is low so a simultaneous pop cannot make room for
    // the incoming byte in the same cycle; when empty, a read is ignored.
    assign push = in_valid && in_ready;
    assign pop  = read && ready;

    dataout_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wp),
        .wdata (in_data),
        .raddr (rp),
        .rdata (mem_rdata)
    );

    // Pointers, occupancy and sticky flags; reset discards any transfer
    // requested in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (read && !ready) begin
                underflow <= 1'b1;
            end
        end
    end

    assign data_out = ready ? mem_rdata : '0;

endmodule

// File: tb/tb_dataout_fifo.sv
// tb_dataout_fifo
// Self-checking bench for dataout_fifo. A queue-based reference model tracks
// the expected contents and sticky flags; directed scenarios are followed by
// a randomized traffic phase.
module tb_dataout_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ready;
    logic       read;
    logic [7:0] data_out;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovf;
    logic       model_udf;

    dataout_fifo #(
        .DW    (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ready     (ready),
        .read      (read),
        .data_out  (data_out),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, from the FIFO's rules
    task automatic modelStep(input logic iv, input logic [7:0] d, input logic rd);
        bit full;
        bit empty;
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        if (iv && full)  model_ovf = 1'b1;
        if (rd && empty) model_udf = 1'b1;
        if (rd && !empty) void'(model_q.pop_front());
        if (iv && !full)  model_q.push_back(d);
    endtask

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        logic [7:0] exp_data;
        exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check({tag, ".ready"},     32'(ready),     32'(model_q.size() != 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() != DEPTH));
        check({tag, ".count"},     32'(count),     32'(model_q.size()));
        check({tag, ".data_out"},  32'(data_out),  32'(exp_data));
        check({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(model_udf));
    endtask

    // Drive one cycle of inputs, advance the model, check 1 unit after the edge
    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic rd, input string tag);
        in_valid = iv;
        in_data  = d;
        read     = rd;
        @(posedge clk);
        modelStep(iv, d, rd);
        #1;
        checkOutput(tag);
        in_valid = 1'b0;
        read     = 1'b0;
    endtask

    // One-cycle reset, optionally with transfer requests that must be discarded
    task automatic doReset(input logic iv, input logic rd);
        rst      = 1'b1;
        in_valid = iv;
        in_data  = 8'hC3;
        read     = rd;
        @(posedge clk);
        model_q.delete();
        model_ovf = 1'b0;
        model_udf = 1'b0;
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        read     = 1'b0;
        checkOutput("reset");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        read      = 1'b0;
        model_ovf = 1'b0;
        model_udf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("por");
        check("por_in_ready", 32'(in_ready), 32'd1);
        check("por_data_out", 32'(data_out), 32'd0);

        // Basic ordering
        applyStimulus(1'b1, 8'h11, 1'b0, "basic_push");
        applyStimulus(1'b1, 8'h22, 1'b0, "basic_push");
        applyStimulus(1'b1, 8'h33, 1'b0, "basic_push");
        check("basic_count3", 32'(count), 32'd3);
        check("basic_head", 32'(data_out), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b1, "basic_pop");
        check("basic_pop1_next", 32'(data_out), 32'h22);
        applyStimulus(1'b0, 8'h00, 1'b1, "basic_pop");
        check("basic_pop2_next", 32'(data_out), 32'h33);
        applyStimulus(1'b0, 8'h00, 1'b1, "basic_pop");
        check("basic_empty_ready", 32'(ready), 32'd0);
        check("basic_empty_data", 32'(data_out), 32'd0);

        // Fill to full, overflow, drain
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, "full_push");
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd16);
        applyStimulus(1'b1, 8'hAA, 1'b0, "full_reject");
        check("full_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("full_drain_data", 32'(data_out), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, "full_drain");
        end
        check("full_drained_ready", 32'(ready), 32'd0);

        // Wrap-around
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, "wrap_push");
            check("wrap_data", 32'(data_out), 32'(8'h40 + i));
            applyStimulus(1'b0, 8'h00, 1'b1, "wrap_pop");
            check("wrap_count_le1", 32'(count <= 5'd1), 32'd1);
        end

        // Full with simultaneous pop and write: write dropped
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, "sim_fill");
        applyStimulus(1'b1, 8'hEE, 1'b1, "sim_full_both");
        check("sim_full_count", 32'(count), 32'd15);
        for (int i = 1; i < DEPTH; i++) begin
            check("sim_full_drain", 32'(data_out), 32'(8'h80 + i));
            applyStimulus(1'b0, 8'h00, 1'b1, "sim_full_drain");
        end
        check("sim_full_no_passthru", 32'(ready), 32'd0);

        // Empty with both: read ignored, write accepted
        applyStimulus(1'b1, 8'h3C, 1'b1, "sim_empty_both");
        check("sim_empty_underflow", 32'(underflow), 32'd1);
        check("sim_empty_count", 32'(count), 32'd1);
        check("sim_empty_data", 32'(data_out), 32'h3C);

        // Half-full with both for 8 cycles
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, "half_fill");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'hD0 + i), 1'b1, "half_both");
            check("half_count_const", 32'(count), 32'd8);
        end

        // Underflow while empty leaves pointers alone
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, "udf_read");
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 8'h77, 1'b0, "udf_push");
        check("udf_push_data", 32'(data_out), 32'h77);
        applyStimulus(1'b0, 8'h00, 1'b1, "udf_pop");

        // Reset mid-operation, with transfers requested during reset
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, "mid_push");
        doReset(1'b1, 1'b1);
        check("mid_count", 32'(count), 32'd0);
        check("mid_ready", 32'(ready), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_flags", 32'({overflow, underflow}), 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b0, "mid_push_after");
        check("mid_first_byte", 32'(data_out), 32'h5A);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45), "rand");
        end

        $display("[TB] directed and random phases complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
